// File: rtl/mem_stage_lanes_pkg.sv
// ============================================================================
// Module : mem_stage_lanes_pkg
// Brief  : Shared access-size encodings, FSM states and lane-mask helper for
//          the MEM stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_stage_lanes_pkg;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_t;

    // Size 2'b10 falls into the word case on purpose.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            MEM_BYTE: return 4'b0001 << off;
            MEM_HALF: return off[1] ? 4'b1100 : 4'b0011;
            default:  return 4'b1111;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_lanes_data_ram.sv
// ============================================================================
// Module : data_ram_bytelane
// Brief  : 32-bit word RAM, per-byte write enables, async read plus an async
//          debug read port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module data_ram_bytelane #(
    parameter int WORD_AW = 6
) (
    input  logic               i_clk,
    input  logic [3:0]         i_we,
    input  logic [WORD_AW-1:0] i_addr,
    input  logic [31:0]        i_wdata,
    output logic [31:0]        o_rdata,
    input  logic [WORD_AW-1:0] i_dbg_addr,
    output logic [31:0]        o_dbg_data
);

    logic [31:0] r_mem [0:(1<<WORD_AW)-1];

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < 4; i++) begin
            if (i_we[i]) begin
                r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    assign o_rdata    = r_mem[i_addr];
    assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

`default_nettype wire

// File: rtl/mem_stage_lanes.sv
// ============================================================================
// Module : mem_stage_lanes
// Brief  : MIPS MEM stage: byte-lane stores, extending loads, misalign flag,
//          configurable access latency with stall, debug read while halted.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_stage_lanes
    import mem_stage_lanes_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int MEM_LATENCY = 0,
    parameter int REG_ADDR_W  = 5
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_halt,
    input  logic [31:0]           i_alu_result,
    input  logic [31:0]           i_store_data,
    input  logic [REG_ADDR_W-1:0] i_write_reg,
    input  logic                  i_wb_write,
    input  logic                  i_wb_mem_to_reg,
    input  logic                  i_mem_read,
    input  logic                  i_mem_write,
    input  logic                  i_mem_unsigned,
    input  logic [1:0]            i_mem_size,
    output logic                  o_stall,
    output logic                  o_misaligned,
    output logic                  o_wb_write,
    output logic                  o_wb_mem_to_reg,
    output logic [31:0]           o_alu_result,
    output logic [31:0]           o_read_data,
    output logic [REG_ADDR_W-1:0] o_write_reg,
    input  logic [ADDR_WIDTH-1:0] i_dbg_addr,
    output logic [31:0]           o_dbg_data
);

    localparam int              CNT_W = (MEM_LATENCY > 0) ? $clog2(MEM_LATENCY + 1) : 1;
    localparam logic [CNT_W-1:0] C_LAT = CNT_W'(MEM_LATENCY);

    mem_state_t              r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_misaligned;
    logic                    r_wb_write;
    logic                    r_wb_mem_to_reg;
    logic [31:0]             r_alu_result;
    logic [31:0]             r_read_data;
    logic [REG_ADDR_W-1:0]   r_write_reg;

    logic [1:0]  w_off;
    logic        w_access;
    logic        w_misaligned;
    logic        w_mem_op;
    logic        w_stall;
    logic        w_capture;
    logic [3:0]  w_we;
    logic [31:0] w_wdata;
    logic [31:0] w_rdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic        w_unused_dbg;

    assign w_off        = i_alu_result[1:0];
    assign w_access     = (i_mem_read | i_mem_write) & ~i_halt;
    assign w_misaligned = w_access &
                          (((i_mem_size == MEM_HALF) & w_off[0]) |
                           (i_mem_size[1] & (w_off != 2'b00)));
    assign w_mem_op     = w_access & ~w_misaligned;

    always_comb begin
        w_stall = 1'b0;
        if (MEM_LATENCY > 0 && !i_halt) begin
            case (r_state)
                ST_IDLE: w_stall = w_mem_op;
                ST_BUSY: w_stall = (r_cnt < C_LAT);
                default: w_stall = 1'b0;
            endcase
        end
    end

    // The write lands on the same edge that MEM/WB captures the instruction.
    assign w_capture = ~i_halt & ~w_stall;
    assign w_we      = (w_capture & i_mem_write & ~w_misaligned)
                       ? lane_mask(i_mem_size, w_off) : 4'b0000;

    always_comb begin
        case (i_mem_size)
            MEM_BYTE: w_wdata = {4{i_store_data[7:0]}};
            MEM_HALF: w_wdata = {2{i_store_data[15:0]}};
            default:  w_wdata = i_store_data;
        endcase
    end

    data_ram_bytelane #(
        .WORD_AW (ADDR_WIDTH - 2)
    ) u_ram (
        .i_clk      (i_clk),
        .i_we       (w_we),
        .i_addr     (i_alu_result[ADDR_WIDTH-1:2]),
        .i_wdata    (w_wdata),
        .o_rdata    (w_rdata),
        .i_dbg_addr (i_dbg_addr[ADDR_WIDTH-1:2]),
        .o_dbg_data (o_dbg_data)
    );

    assign w_unused_dbg = ^i_dbg_addr[1:0];

    assign w_byte = w_rdata[{w_off, 3'b000} +: 8];
    assign w_half = w_off[1] ? w_rdata[31:16] : w_rdata[15:0];

    always_comb begin
        case (i_mem_size)
            MEM_BYTE: w_load_data = {{24{~i_mem_unsigned & w_byte[7]}}, w_byte};
            MEM_HALF: w_load_data = {{16{~i_mem_unsigned & w_half[15]}}, w_half};
            default:  w_load_data = w_rdata;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= ST_IDLE;
            r_cnt           <= '0;
            r_misaligned    <= 1'b0;
            r_wb_write      <= 1'b0;
            r_wb_mem_to_reg <= 1'b0;
            r_alu_result    <= '0;
            r_read_data     <= '0;
            r_write_reg     <= '0;
        end else if (!i_halt) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_stall) begin
                        r_state <= ST_BUSY;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                ST_BUSY: begin
                    if (r_cnt < C_LAT) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // A stalled cycle hands a bubble to MEM/WB.
            if (w_stall) begin
                r_misaligned    <= 1'b0;
                r_wb_write      <= 1'b0;
                r_wb_mem_to_reg <= 1'b0;
                r_alu_result    <= '0;
                r_read_data     <= '0;
                r_write_reg     <= '0;
            end else begin
                r_misaligned    <= w_misaligned;
                r_wb_write      <= i_wb_write & ~w_misaligned;
                r_wb_mem_to_reg <= i_wb_mem_to_reg;
                r_alu_result    <= i_alu_result;
                r_read_data     <= (i_mem_read & ~w_misaligned) ? w_load_data : '0;
                r_write_reg     <= i_write_reg;
            end
        end
    end

    assign o_stall         = w_stall;
    assign o_misaligned    = r_misaligned;
    assign o_wb_write      = r_wb_write;
    assign o_wb_mem_to_reg = r_wb_mem_to_reg;
    assign o_alu_result    = r_alu_result;
    assign o_read_data     = r_read_data;
    assign o_write_reg     = r_write_reg;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_lanes.sv
// ============================================================================
// Module : tb_mem_stage_lanes
// Brief  : Bench for mem_stage_lanes with a zero-latency and a 3-cycle
//          instance sharing stimulus, checked against a byte-array model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_stage_lanes;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, halt, rd, wr, uns, wbw, m2r, mask0;
    logic [1:0]  sz;
    logic [31:0] alu, sdata;
    logic [4:0]  wreg;
    logic [7:0]  dbg;
    wire         wr0 = wr & ~mask0;

    logic        st0, mis0, wbw0, m2r0, st3, mis3, wbw3, m2r3;
    logic [31:0] alu0, rdat0, dbgd0, alu3, rdat3, dbgd3;
    logic [4:0]  wreg0, wreg3;

    mem_stage_lanes #(.ADDR_WIDTH(8), .MEM_LATENCY(0), .REG_ADDR_W(5)) dut0 (
        .i_clk(clk), .i_reset(rst), .i_halt(halt), .i_alu_result(alu),
        .i_store_data(sdata), .i_write_reg(wreg), .i_wb_write(wbw),
        .i_wb_mem_to_reg(m2r), .i_mem_read(rd), .i_mem_write(wr0),
        .i_mem_unsigned(uns), .i_mem_size(sz), .o_stall(st0),
        .o_misaligned(mis0), .o_wb_write(wbw0), .o_wb_mem_to_reg(m2r0),
        .o_alu_result(alu0), .o_read_data(rdat0), .o_write_reg(wreg0),
        .i_dbg_addr(dbg), .o_dbg_data(dbgd0));

    mem_stage_lanes #(.ADDR_WIDTH(8), .MEM_LATENCY(3), .REG_ADDR_W(5)) dut3 (
        .i_clk(clk), .i_reset(rst), .i_halt(halt), .i_alu_result(alu),
        .i_store_data(sdata), .i_write_reg(wreg), .i_wb_write(wbw),
        .i_wb_mem_to_reg(m2r), .i_mem_read(rd), .i_mem_write(wr),
        .i_mem_unsigned(uns), .i_mem_size(sz), .o_stall(st3),
        .o_misaligned(mis3), .o_wb_write(wbw3), .o_wb_mem_to_reg(m2r3),
        .o_alu_result(alu3), .o_read_data(rdat3), .o_write_reg(wreg3),
        .i_dbg_addr(dbg), .o_dbg_data(dbgd3));

    int checks   = 0;
    int failures = 0;

    logic [7:0] mm [0:255];
    bit         mv [0:255];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rd = 0; wr = 0; uns = 0; sz = 2'b00; alu = '0; sdata = '0;
        wreg = '0; wbw = 0; m2r = 0;
    endtask

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic is_mis(input logic [1:0] s, input logic [7:0] a);
        return (s == 2'b01 && a[0]) || (s[1] && a[1:0] != 2'b00);
    endfunction

    // Little-endian byte-array view of memory.
    function automatic logic [31:0] m_load(input logic [1:0] s, input logic [7:0] a,
                                           input logic u, output logic known);
        logic [31:0] v = '0;
        logic [7:0]  idx;
        int n = nbytes(s);
        known = 1'b1;
        for (int i = 0; i < n; i++) begin
            idx = a + 8'(i);
            v[8*i +: 8] = mm[idx];
            if (!mv[idx]) known = 1'b0;
        end
        if (!u) for (int i = 8*n; i < 32; i++) v[i] = v[8*n-1];
        return v;
    endfunction

    task automatic m_store(input logic [1:0] s, input logic [7:0] a, input logic [31:0] d);
        logic [7:0] idx;
        for (int i = 0; i < nbytes(s); i++) begin
            idx = a + 8'(i);
            mm[idx] = d[8*i +: 8];
            mv[idx] = 1'b1;
        end
    endtask

    task automatic do_op(input logic r, input logic w, input logic u, input logic [1:0] s,
                         input logic [31:0] al, input logic [31:0] d, input logic [4:0] rg);
        logic mis, mem, known;
        logic [31:0] ev;
        int edges;
        @(negedge clk);
        rd = r; wr = w; uns = u; sz = s; alu = al; sdata = d; wreg = rg; wbw = r; m2r = r;
        mis = (r | w) && is_mis(s, al[7:0]);
        mem = (r | w) && !mis;
        ev  = m_load(s, al[7:0], u, known);
        if (w && !mis) m_store(s, al[7:0], d);
        #1;
        check("stall0", {31'b0, st0}, 32'd0);
        check("stall3_issue", {31'b0, st3}, {31'b0, mem});
        tick();
        edges = 1;
        check("wbw0", {31'b0, wbw0}, {31'b0, r && !mis});
        check("mis0", {31'b0, mis0}, {31'b0, mis});
        check("alu0", alu0, al);
        check("wreg0", {27'b0, wreg0}, {27'b0, rg});
        if (r && !mis && known) check("rdata0", rdat0, ev);
        if (mem) begin
            check("bubble3_ctl", {24'b0, wbw3, m2r3, mis3, wreg3}, 32'd0);
            check("bubble3_data", alu3 | rdat3, 32'd0);
            while (st3 === 1'b1 && edges < 8) begin
                tick();
                edges++;
                check("bubble3_ctl", {24'b0, wbw3, m2r3, mis3, wreg3}, 32'd0);
                check("bubble3_data", alu3 | rdat3, 32'd0);
            end
            tick();
            edges++;
            check("latency3", 32'(edges), 32'd4);
        end
        check("wbw3", {31'b0, wbw3}, {31'b0, r && !mis});
        check("m2r3", {31'b0, m2r3}, {31'b0, r});
        check("mis3", {31'b0, mis3}, {31'b0, mis});
        check("alu3", alu3, al);
        check("wreg3", {27'b0, wreg3}, {27'b0, rg});
        if (r && !mis && known) check("rdata3", rdat3, ev);
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        kr, kw;
        int          kind;
        for (int i = 0; i < 256; i++) begin mm[i] = 8'h00; mv[i] = 1'b0; end
        rst = 1; halt = 0; mask0 = 0; dbg = '0;
        idle_inputs();
        tick(); tick();
        check("reset0_out", {24'b0, wbw0, m2r0, mis0, wreg0} | alu0 | rdat0, 32'd0);
        check("reset3_out", {24'b0, wbw3, m2r3, mis3, wreg3} | alu3 | rdat3, 32'd0);
        check("reset3_stall", {31'b0, st3}, 32'd0);
        @(negedge clk);
        rst = 0;

        do_op(0, 1, 0, 2'b11, 32'h10, 32'hDEADBEEF, 5'd0);
        do_op(1, 0, 0, 2'b00, 32'h11, 32'h0, 5'd3);
        check("lb_11", rdat3, 32'hFFFFFFBE);
        do_op(1, 0, 1, 2'b00, 32'h13, 32'h0, 5'd4);
        check("lbu_13", rdat3, 32'h000000DE);

        do_op(0, 1, 0, 2'b11, 32'h20, 32'h11223344, 5'd0);
        do_op(0, 1, 0, 2'b01, 32'h22, 32'h0000AAAA, 5'd0);
        do_op(1, 0, 0, 2'b11, 32'h20, 32'h0, 5'd5);
        check("lw_20", rdat3, 32'hAAAA3344);
        do_op(1, 0, 0, 2'b01, 32'h22, 32'h0, 5'd6);
        check("lh_22", rdat0, 32'hFFFFAAAA);

        do_op(0, 1, 0, 2'b11, 32'h04, 32'h01020304, 5'd0);
        do_op(1, 0, 0, 2'b11, 32'h06, 32'h0, 5'd8);
        do_op(0, 1, 0, 2'b11, 32'h05, 32'hFFFFFFFF, 5'd0);
        do_op(1, 0, 0, 2'b11, 32'h04, 32'h0, 5'd9);
        check("lw_04_kept", rdat3, 32'h01020304);

        // Halt in the middle of a 3-cycle wait.
        @(negedge clk);
        rd = 1; wbw = 1; m2r = 1; sz = 2'b11; alu = 32'h20; wreg = 5'd7;
        tick(); tick();
        @(negedge clk);
        halt = 1;
        #1;
        check("halt_stall3", {31'b0, st3}, 32'd0);
        check("halt_stall0", {31'b0, st0}, 32'd0);
        tick(); tick(); tick();
        check("halt_hold3", {31'b0, wbw3}, 32'd0);
        check("halt_hold0", rdat0, 32'hAAAA3344);
        @(negedge clk);
        halt = 0;
        #1;
        check("resume_stall", {31'b0, st3}, 32'd1);
        tick();
        check("resume_last", {31'b0, st3}, 32'd0);
        tick();
        check("resume_data", rdat3, 32'hAAAA3344);
        check("resume_wbw", {31'b0, wbw3}, 32'd1);
        @(negedge clk);
        idle_inputs();

        // Debug read while halted; the store must be blocked.
        @(negedge clk);
        halt = 1; wr = 1; sz = 2'b11; alu = 32'h20; sdata = 32'h55555555; dbg = 8'h20;
        #1;
        check("dbg3", dbgd3, 32'hAAAA3344);
        tick(); tick();
        check("dbg3_after", dbgd3, 32'hAAAA3344);
        check("dbg0_after", dbgd0, 32'hAAAA3344);
        @(negedge clk);
        halt = 0;
        idle_inputs();
        #1;
        check("dbg3_release", dbgd3, 32'hAAAA3344);
        do_op(1, 0, 0, 2'b11, 32'h20, 32'h0, 5'd10);

        // Reset during a pending store on the slow instance.
        do_op(0, 1, 0, 2'b11, 32'h30, 32'hCAFEF00D, 5'd0);
        @(negedge clk);
        mask0 = 1; wr = 1; sz = 2'b11; alu = 32'h30; sdata = 32'h12345678;
        tick(); tick();
        @(negedge clk);
        rst = 1;
        tick();
        check("rst_busy_out", {24'b0, wbw3, m2r3, mis3, wreg3} | alu3 | rdat3, 32'd0);
        @(negedge clk);
        rst = 0; mask0 = 0;
        idle_inputs();
        #1;
        check("rst_busy_stall", {31'b0, st3}, 32'd0);
        do_op(1, 0, 0, 2'b11, 32'h30, 32'h0, 5'd11);
        check("lw_30_old", rdat3, 32'hCAFEF00D);

        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 2));
            kr = (kind == 1);
            kw = (kind == 2);
            if (kind == 0)
                do_op(0, 0, 1'($urandom), 2'($urandom), $urandom, $urandom, 5'($urandom));
            else
                do_op(kr, kw, 1'($urandom), 2'($urandom),
                      32'(8'h40 + 8'($urandom_range(0, 31))), $urandom, 5'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
